bfly_inject_port: RTL

//  Terminal-side injection stage directly upstream of switch_node_4rad in the symmetric butterfly.

---
 rtl/bfly_inject_port.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/bfly_inject_port.sv
`default_nettype none
// ============================================================================
//  Module      : bfly_inject_port
//  Description : Terminal-side injection stage for the symmetric butterfly.
//                Buffers whole packets in a FIFO (store-and-forward) and then
//                serialises each one onto an 18-bit channel with no
//                backpressure: one header flit followed by the payload flits.
//                Optional macro INJ_GAP_EN inserts one null flit after every
//                packet so the downstream allocator can release its grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module bfly_inject_port #(
  parameter int DEST_W     = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_data,
  input  logic              in_last,
  input  logic [DEST_W-1:0] in_dest,
  output logic [17:0]       out_ch,
  output logic              busy,
  output logic              err_stall
);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_PW = c_AW + 1;
  localparam int c_EW = 2 + DEST_W + 16;
  localparam logic [c_PW-1:0] c_ONE = 1;

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_HEADER  = 2'd1;
  localparam logic [1:0] c_ST_PAYLOAD = 2'd2;
`ifdef INJ_GAP_EN
  localparam logic [1:0] c_ST_GAP     = 2'd3;
`endif

  // Entry layout: {first, last, dest, data}
  logic [c_EW-1:0]   r_mem [FIFO_DEPTH];
  logic [c_PW-1:0]   r_wr_ptr;
  logic [c_PW-1:0]   r_rd_ptr;
  logic [c_PW-1:0]   r_pkt_cnt;
  logic              r_next_first;
  logic              r_err;
  logic [1:0]        r_state;
  logic [17:0]       r_out;
  logic              r_cur_last;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_pop_req;
  logic              w_idle_rules;
  logic              w_start;
  logic [c_EW-1:0]   w_head;
  logic [15:0]       w_head_data;
  logic [DEST_W-1:0] w_head_dest;
  logic              w_head_last;
  logic              w_head_first;
  logic              w_pkt_inc;
  logic              w_pkt_dec;
  logic [1:0]        w_state_nxt;
  logic [17:0]       w_out_nxt;
  logic              w_cur_last_nxt;

  // The extra wrap bit distinguishes full from empty when the indices match.
  assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  assign in_ready = !w_full && !rst;
  assign w_push   = in_valid && in_ready;

  assign w_head       = r_mem[r_rd_ptr[c_AW-1:0]];
  assign w_head_data  = w_head[15:0];
  assign w_head_dest  = w_head[16 +: DEST_W];
  assign w_head_last  = w_head[16 + DEST_W];
  assign w_head_first = w_head[17 + DEST_W];

  // A packet may start only once it is fully buffered, so payload never underflows.
  assign w_start   = (r_pkt_cnt != '0) && w_head_first;
  assign w_pop     = w_pop_req && !w_empty;
  assign w_pkt_inc = w_push && in_last;
  assign w_pkt_dec = w_pop && w_head_last;

  // Payload storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= {r_next_first, in_last, in_dest, in_data};
    end
  end

  // FIFO pointers, packet counter, start-of-packet tracking and sticky stall flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_pkt_cnt    <= '0;
      r_next_first <= 1'b1;
      r_err        <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr     <= r_wr_ptr + c_ONE;
        r_next_first <= in_last;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ONE;
      end
      case ({w_pkt_inc, w_pkt_dec})
        2'b10:   r_pkt_cnt <= r_pkt_cnt + c_ONE;
        2'b01:   r_pkt_cnt <= r_pkt_cnt - c_ONE;
        default: r_pkt_cnt <= r_pkt_cnt;
      endcase
      // Full with no complete packet means the packet can never drain.
      if (w_full && (r_pkt_cnt == '0)) begin
        r_err <= 1'b1;
      end
    end
  end

  // Serialiser next-state: pops drive payload flits, idle rules may start a header.
  always_comb begin
    w_state_nxt    = r_state;
    w_out_nxt      = 18'h0;
    w_cur_last_nxt = r_cur_last;
    w_pop_req      = 1'b0;
    w_idle_rules   = 1'b0;
    case (r_state)
      c_ST_IDLE:    w_idle_rules = 1'b1;
      c_ST_HEADER:  w_pop_req    = 1'b1;
      c_ST_PAYLOAD: begin
        if (!r_cur_last) begin
          w_pop_req = 1'b1;
        end else begin
`ifdef INJ_GAP_EN
          w_state_nxt = c_ST_GAP;
`else
          w_idle_rules = 1'b1;
`endif
        end
      end
`ifdef INJ_GAP_EN
      c_ST_GAP:     w_idle_rules = 1'b1;
`endif
      default:      w_state_nxt  = c_ST_IDLE;
    endcase
    if (w_pop) begin
      w_out_nxt      = {2'b10, w_head_data};
      w_cur_last_nxt = w_head_last;
      w_state_nxt    = c_ST_PAYLOAD;
    end else if (w_idle_rules) begin
      if (w_start) begin
        w_out_nxt   = {2'b11, w_head_dest, {(16-DEST_W){1'b0}}};
        w_state_nxt = c_ST_HEADER;
      end else begin
        w_state_nxt = c_ST_IDLE;
      end
    end
  end

  // Registered channel output and FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_ST_IDLE;
      r_out      <= 18'h0;
      r_cur_last <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_out      <= w_out_nxt;
      r_cur_last <= w_cur_last_nxt;
    end
  end

  assign out_ch    = r_out;
  assign busy      = (r_state != c_ST_IDLE);
  assign err_stall = r_err;

endmodule
`default_nettype wire
